bcd_scan_decoder: RTL
=====================

Name: bcd_scan_decoder

Overview:
- Parametrised multi-digit successor to the single-digit BCD-to-decimal decoder.
- Accepts a packed NUM_DIGITS-digit BCD word over a valid/ready handshake and time-multiplexes it one digit at a time.
- Each displayed digit appears as a one-hot decimal code plus a one-hot digit select, with optional leading-zero blanking, invalid-code flagging, and one-shot or continuous refresh.
- Sits between the counter/arithmetic datapath and the multiplexed display driver.

Parameters:
NUM_DIGITS, 4, number of BCD digits (>=1); digit 0 = least significant.
SCAN_DIV, 4, clock cycles each digit is held (>=1).
CONTINUOUS, 0, 0 = scan frame once then idle; 1 = repeat frames until reset.
BLANK_LZ, 1, 1 = blank leading zeros above the most significant nonzero digit.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_bcd is valid.
in_ready  output  1  block can accept in_bcd.
in_bcd  input  4*NUM_DIGITS  packed BCD; digit i = bits [4i+3:4i].
dec_out  output  10  one-hot decimal of current digit; bit n set for value n.
dig_sel  output  NUM_DIGITS  one-hot select of current digit.
blank  output  1  current digit is blanked by leading-zero rule.
digit_err  output  1  current digit code is 10..15.
err_sticky  output  1  any invalid code seen in current word.
frame_done  output  1  one-cycle pulse at end of each full frame.

Behaviour:
- Clocking and reset: single clock domain. rst_n low asynchronously forces IDLE, clears all registers, and drives every output to 0 (including in_ready). After release, in_ready=1 on the first cycle.
- Output timing: all outputs are driven from registers only; there is no combinational path from in_* to any output.
- States: IDLE, SCAN.
- IDLE:
  - in_ready=1; dec_out=0, dig_sel=0, blank=0, digit_err=0.
  - On in_valid&&in_ready at edge k: capture in_bcd into the active register, clear err_sticky, set idx=0 and div=0, enter SCAN.
  - Digit 0 is visible in the cycle after edge k (latency 1).
- SCAN:
  - Shows digit idx: dig_sel=1<<idx.
  - div counts 0..SCAN_DIV-1; at div=SCAN_DIV-1, div wraps to 0 and idx advances.
  - Each digit is held exactly SCAN_DIV cycles.
- Decoding per digit d:
  - d<=9: dec_out=1<<d, digit_err=0.
  - d>=10: dec_out=0, digit_err=1, err_sticky set.
- Leading-zero blanking (BLANK_LZ=1):
  - Digit i is blanked iff i>0 and all digits j>=i are 0.
  - Blanked digit: dec_out=0, blank=1, dig_sel still asserted.
  - Invalid codes count as nonzero.
  - All-zero word shows a single "0" in digit 0.
  - With BLANK_LZ=0, blank is always 0.
- End of frame (idx=NUM_DIGITS-1, div=SCAN_DIV-1), at that edge:
  - frame_done=1 for the following cycle.
  - CONTINUOUS=0: go to IDLE; in_ready=0 throughout SCAN.
  - CONTINUOUS=1: idx wraps to 0, stay in SCAN. If a pending word exists, it moves into the active register, the pending flag clears, and err_sticky is cleared before decoding the new word.
- CONTINUOUS=1 pending-word handling:
  - in_ready = pending register empty.
  - A handshake in SCAN writes the pending register.
  - A handshake coinciding with the frame-end edge writes pending, not active; it is applied at the next frame end.
- err_sticky: set by any displayed invalid digit; cleared only by reset or by loading a new active word.
- Non-handshake in_valid (in_ready=0): ignored; data is not latched.
- SCAN_DIV=1: idx advances every cycle. NUM_DIGITS=1: every frame-end is at idx 0.
- Reset mid-scan: immediate return to IDLE with outputs 0; the pending word is discarded.

Test Plan:
- NUM_DIGITS=4, SCAN_DIV=2, CONTINUOUS=0, BLANK_LZ=0. Load 16'h1239 → 8 cycles: dec_out 0x200,0x200,0x008,0x008,0x004,0x004,0x002,0x002; dig_sel 1,1,2,2,4,4,8,8; frame_done on cycle 9; in_ready=1 cycle 9.
- Same configuration with BLANK_LZ=1. Load 16'h0050 → digit0 dec_out=0x001, digit1 0x020, digits 2 and 3 blank=1 with dec_out=0. Load 16'h0000 → only digit 3 and digit 2 and digit 1 blanked; digit 0 dec_out=0x001.
- Load 16'h0A07 → digit 2 window: digit_err=1, dec_out=0. err_sticky=1 from that window until the next load; next load 16'h0001 clears it.
- CONTINUOUS=1. Load 16'h1111, then mid-frame load 16'h2222 → remainder of frame shows 1s, next frame shows 2s. in_ready=0 from pending write until frame end. frame_done pulses every 8 cycles.
- Assert rst_n=0 during digit 2 of a scan → all outputs 0 immediately, without waiting for a clock edge. After release: in_ready=1, IDLE state, no stale digits shown.
- Hold in_valid=1 with in_ready=0 in one-shot mode, changing in_bcd each cycle → displayed word unchanged; new word accepted only on the IDLE handshake.

Source files
------------

// File: rtl/bcd_scan_decoder.sv
// bcd_scan_decoder
//
// Time-multiplexes a packed NUM_DIGITS-digit BCD word onto a display one
// digit at a time. Each visible digit is shown as a one-hot decimal code
// plus a one-hot digit select. The block also provides:
//   - optional leading-zero blanking
//   - per-digit and sticky invalid-code flags
//   - one-shot or continuous refresh
//
// Parameters:
//   NUM_DIGITS - number of BCD digits (digit 0 is least significant)
//   SCAN_DIV   - clock cycles each digit is held
//   CONTINUOUS - 0: scan one frame then idle, 1: repeat frames
//   BLANK_LZ   - 1: blank zeros above the most significant nonzero digit
//
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   in_valid    - in_bcd holds a word to load
//   in_ready    - block accepts a word on this cycle
//   in_bcd      - packed BCD word, digit i = bits [4i+3:4i]
//   dec_out     - one-hot decimal value of the current digit
//   dig_sel     - one-hot select of the current digit
//   blank       - current digit is suppressed as a leading zero
//   digit_err   - current digit code is 10..15
//   err_sticky  - an invalid digit was shown for the current word
//   frame_done  - one-cycle pulse after the last digit of a frame
//
// Every output comes straight from a flop. The output flops are loaded
// from the *next* scan position, so the first digit is visible in the
// cycle right after the accepting edge.

module bcd_scan_decoder #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 4,
  parameter int CONTINUOUS = 0,
  parameter int BLANK_LZ   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_bcd,
  output logic [9:0]              dec_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    blank,
  output logic                    digit_err,
  output logic                    err_sticky,
  output logic                    frame_done
);

  localparam int WW = 4 * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(SCAN_DIV - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                state_q, state_d;
  logic [WW-1:0]         active_q, active_d;
  logic [WW-1:0]         pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         div_q, div_d;
  logic [9:0]            dec_out_q, dec_out_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic                  blank_q, blank_d;
  logic                  digit_err_q, digit_err_d;
  logic                  err_sticky_q, err_sticky_d;
  logic                  frame_done_q, frame_done_d;
  logic                  in_ready_q, in_ready_d;

  logic                  hs;
  logic                  load;
  logic [3:0]            cur_digit;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  all_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      active_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      idx_q        <= '0;
      div_q        <= '0;
      dec_out_q    <= '0;
      dig_sel_q    <= '0;
      blank_q      <= 1'b0;
      digit_err_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      frame_done_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      idx_q        <= idx_d;
      div_q        <= div_d;
      dec_out_q    <= dec_out_d;
      dig_sel_q    <= dig_sel_d;
      blank_q      <= blank_d;
      digit_err_q  <= digit_err_d;
      err_sticky_q <= err_sticky_d;
      frame_done_q <= frame_done_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // Scan sequencing: the state, the word and the position that will be
  // shown in the next cycle.
  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    idx_d        = idx_q;
    div_d        = div_q;
    frame_done_d = 1'b0;
    load         = 1'b0;
    hs           = in_valid && in_ready_q;

    case (state_q)
      IDLE: begin
        if (hs) begin
          active_d = in_bcd;
          idx_d    = '0;
          div_d    = '0;
          state_d  = SCAN;
          load     = 1'b1;
        end
      end
      SCAN: begin
        if (div_q == LAST_DIV) begin
          div_d = '0;
          if (idx_q == LAST_IDX) begin
            frame_done_d = 1'b1;
            if (CONTINUOUS != 0) begin
              idx_d = '0;
              if (pend_valid_q) begin
                active_d     = pend_q;
                pend_valid_d = 1'b0;
                load         = 1'b1;
              end
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          div_d = div_q + DW'(1);
        end
        // A word accepted during a scan waits in the pending register,
        // even on the frame-end edge, and goes live at the next frame end.
        // in_ready was low whenever pend_valid_q was set, so this cannot
        // overwrite a word that is swapped in on the same edge.
        if ((CONTINUOUS != 0) && hs) begin
          pend_d       = in_bcd;
          pend_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decode the digit that will be shown next.
  // Scanning the word from the top finds every zero that lies above the
  // most significant nonzero digit. Digit 0 is never blanked, so an
  // all-zero word still shows "0". Invalid codes are nonzero and
  // therefore stop the blanking.
  always_comb begin
    cur_digit    = 4'd0;
    all_zero     = 1'b1;
    lz_mask      = '0;
    dig_sel_d    = '0;
    dec_out_d    = '0;
    blank_d      = 1'b0;
    digit_err_d  = 1'b0;

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) cur_digit = active_d[4*i +: 4];
    end

    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero   = all_zero && (active_d[4*i +: 4] == 4'd0);
      lz_mask[i] = (i > 0) && all_zero && (BLANK_LZ != 0);
    end

    if (state_d == SCAN) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dig_sel_d[i] = (idx_d == IW'(i));
        if (idx_d == IW'(i)) blank_d = lz_mask[i];
      end
      digit_err_d = (cur_digit > 4'd9);
      if (!digit_err_d && !blank_d) begin
        for (int n = 0; n < 10; n++) begin
          dec_out_d[n] = (cur_digit == 4'(n));
        end
      end
    end

    // Loading a new word restarts the error history. The first digit of
    // that word can set the flag again straight away.
    err_sticky_d = load ? digit_err_d : (err_sticky_q || digit_err_d);
    in_ready_d   = (state_d == IDLE) || ((CONTINUOUS != 0) && !pend_valid_d);
  end

  assign in_ready   = in_ready_q;
  assign dec_out    = dec_out_q;
  assign dig_sel    = dig_sel_q;
  assign blank      = blank_q;
  assign digit_err  = digit_err_q;
  assign err_sticky = err_sticky_q;
  assign frame_done = frame_done_q;

endmodule
